branch_predict_resolver: RTL and testbench
==========================================

BRANCH_PREDICT_RESOLVER -- requirements
Module: branch_predict_resolver

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, branch-history-table depth; power of two, at least 2.
REQ-003 SHALL have parameter PREDICT_MODE, default PRED_BIMODAL; PRED_STATIC_NT selects always-not-taken.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port d_pc  input  XLEN  decode-stage PC used for prediction lookup.
REQ-007 SHALL have port d_pred_taken  output  1  prediction for the branch at d_pc.
REQ-008 SHALL have port e_valid  input  1  execute stage holds a real, non-bubble instruction.
REQ-009 SHALL have port e_stall  input  1  execute stage frozen this cycle.
REQ-010 SHALL have port e_is_branch  input  1  conditional branch in execute.
REQ-011 SHALL have port e_is_jump  input  1  JAL/JALR in execute.
REQ-012 SHALL have port e_pc  input  XLEN  execute-stage PC.
REQ-013 SHALL have port e_pred_taken  input  1  prediction carried down the pipe with the instruction.
REQ-014 SHALL have port e_actual_taken  input  1  resolved branch outcome.
REQ-015 SHALL have port e_target  input  XLEN  resolved taken target (PC+imm or ALU).
REQ-016 SHALL have port flag  output  1  mispredict this cycle.
REQ-017 SHALL have ports flush_d and flush_e  output  1 each  flush decode and execute registers.
REQ-018 SHALL have port redirect_pc  output  XLEN  correct next PC when flag=1.
REQ-019 SHALL have port mispredict_count  output  32  saturating mispredict tally.

Function
REQ-020 SHALL define index = pc[log2(BHT_ENTRIES)+1:2]; pc[1:0] ignored.
REQ-021 SHALL drive d_pred_taken combinationally: bimodal = MSB of BHT[index(d_pc)]; static mode = 0.
REQ-022 SHALL define active = e_valid & !e_stall; flag, flush_d, flush_e and all state updates are gated by active.
REQ-023 SHALL assert flag=flush_d=flush_e=1 combinationally, zero latency, when active & e_is_jump; redirect_pc=e_target.
REQ-024 SHALL assert flag=flush_d=flush_e=1 when active & e_is_branch & (e_pred_taken != e_actual_taken); redirect_pc = e_actual_taken ? e_target : e_pc+4 (mod 2^XLEN).
REQ-025 SHALL otherwise hold flag=flush_d=flush_e=0 and redirect_pc=0.
REQ-026 SHALL update BHT[index(e_pc)] at the next edge when active & e_is_branch: taken increments, not-taken decrements, each saturating in the 2-bit range 00..11.
REQ-027 SHALL NOT update the BHT on jumps, when e_stall=1, or when e_valid=0.
REQ-028 SHALL return the pre-update value when d_pc and e_pc hit the same index in the same cycle (no bypass).
REQ-029 SHALL increment mispredict_count on every edge where flag=1 and hold it at 0xFFFF_FFFF once saturated.
REQ-030 SHALL, in static mode, leave the BHT unused and constant; flag behaviour is unchanged.
REQ-031 SHALL treat e_is_branch and e_is_jump both high as a jump.

Reset
REQ-032 SHALL, while rst_n=0, immediately set every BHT entry to WEAK_NT (01) and mispredict_count to 0.
REQ-033 SHALL, while rst_n=0, force flag, flush_d and flush_e to 0.
REQ-034 SHALL abandon any in-flight update when reset is asserted between edges, leaving no partial write.

Structure
REQ-035 SHALL place bht_state_t (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) and the pred_mode_t constants PRED_STATIC_NT and PRED_BIMODAL in riscv_defines.
REQ-036 SHALL hold the counter array in one sub-module, bht_table, with one read port, one write port and async reset; the resolve logic stays in the top module.

Verification
REQ-037 SHALL check reset: d_pred_taken=0 for all 16 indices and mispredict_count=0.
REQ-038 SHALL check training: four taken branches at e_pc=0x100 → entry 0 reaches 11; then d_pc=0x100 gives d_pred_taken=1, and a fifth taken branch leaves the entry at 11.
REQ-039 SHALL check a branch mispredict: e_pc=0x200, pred=1, actual=0 → flag, flush_d, flush_e=1 and redirect_pc=0x204 in the same cycle; count increments by 1.
REQ-040 SHALL check jump and stall: a jump with e_target=0x80 → flag=1, redirect_pc=0x80, BHT unchanged; the same mispredict stimulus with e_stall=1 → flag=0 and no update.
REQ-041 SHALL check a same-index hazard: d_pc=e_pc=0x40 with an update → old prediction this cycle, new value next cycle.
REQ-042 SHALL check static mode and saturation: PRED_STATIC_NT gives d_pred_taken always 0; a count preloaded to 0xFFFF_FFFE reaches 0xFFFF_FFFF and holds there.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared types for the branch predictor: 2-bit counter states, prediction modes
// and the saturating counter step.
package riscv_defines;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_state_t;

  typedef enum logic {
    PRED_STATIC_NT = 1'b0,
    PRED_BIMODAL   = 1'b1
  } pred_mode_t;

  // Taken moves toward STRONG_T, not-taken toward STRONG_NT; both ends saturate.
  function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
    bht_state_t nxt;
    nxt = cur;
    case (cur)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
      default:   nxt = WEAK_NT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit counters, one combinational read port and
// one read-modify-write update port, asynchronously reset to WEAK_NT.
module bht_table
  import riscv_defines::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_t       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_t entries [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries[i] <= WEAK_NT;
      end
    end else if (wr_en) begin
      entries[wr_idx] <= bht_next(entries[wr_idx], wr_taken);
    end
  end

  // Read sees the stored value only, so a same-cycle update is not bypassed.
  assign rd_state = entries[rd_idx];

endmodule

// File: rtl/branch_predict_resolver.sv
// Decode-stage branch prediction and execute-stage resolution: flags mispredicts
// and jumps, produces the redirect PC and keeps a saturating mispredict tally.
module branch_predict_resolver
  import riscv_defines::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BHT_ENTRIES  = 16,
  parameter pred_mode_t  PREDICT_MODE = PRED_BIMODAL
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] d_pc,
  output logic            d_pred_taken,
  input  logic            e_valid,
  input  logic            e_stall,
  input  logic            e_is_branch,
  input  logic            e_is_jump,
  input  logic [XLEN-1:0] e_pc,
  input  logic            e_pred_taken,
  input  logic            e_actual_taken,
  input  logic [XLEN-1:0] e_target,
  output logic            flag,
  output logic            flush_d,
  output logic            flush_e,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam bit BIMODAL = (PREDICT_MODE == PRED_BIMODAL);

  logic [IDX_W-1:0] d_idx;
  logic [IDX_W-1:0] e_idx;
  bht_state_t       d_state;
  logic             active;
  logic             bht_we;
  logic [XLEN-1:0]  e_pc_next;
  logic [31:0]      mispredict_count_q;

  assign d_idx     = d_pc[IDX_W+1:2];
  assign e_idx     = e_pc[IDX_W+1:2];
  assign active    = e_valid & ~e_stall;
  assign e_pc_next = e_pc + XLEN'(4);

  // A jump wins over a simultaneous branch indication and never trains the table.
  assign bht_we = BIMODAL & active & e_is_branch & ~e_is_jump;

  bht_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (d_idx),
    .rd_state (d_state),
    .wr_en    (bht_we),
    .wr_idx   (e_idx),
    .wr_taken (e_actual_taken)
  );

  assign d_pred_taken = BIMODAL ? d_state[1] : 1'b0;

  always_comb begin
    flag        = 1'b0;
    redirect_pc = '0;
    if (rst_n && active) begin
      if (e_is_jump) begin
        flag        = 1'b1;
        redirect_pc = e_target;
      end else if (e_is_branch && (e_pred_taken != e_actual_taken)) begin
        flag        = 1'b1;
        redirect_pc = e_actual_taken ? e_target : e_pc_next;
      end
    end
  end

  assign flush_d = flag;
  assign flush_e = flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_count_q <= '0;
    end else if (flag && (mispredict_count_q != 32'hFFFF_FFFF)) begin
      mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_resolver.sv
// Randomized bench for branch_predict_resolver with a behavioural model of the
// prediction table and mispredict tally, plus directed literal checks.
module tb_branch_predict_resolver;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d_pc;
  logic        e_valid, e_stall, e_is_branch, e_is_jump;
  logic [31:0] e_pc, e_target;
  logic        e_pred_taken, e_actual_taken;

  logic        d_pred_taken, flag, flush_d, flush_e;
  logic [31:0] redirect_pc, mispredict_count;
  logic        s_pred_taken, s_flag, s_flush_d, s_flush_e;
  logic [31:0] s_redirect_pc, s_count;

  int          checks = 0;
  int          errors = 0;
  int          m_bht [16];
  logic [31:0] m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  branch_predict_resolver u_dut (
    .clk(clk), .rst_n(rst_n), .d_pc(d_pc), .d_pred_taken(d_pred_taken),
    .e_valid(e_valid), .e_stall(e_stall), .e_is_branch(e_is_branch),
    .e_is_jump(e_is_jump), .e_pc(e_pc), .e_pred_taken(e_pred_taken),
    .e_actual_taken(e_actual_taken), .e_target(e_target), .flag(flag),
    .flush_d(flush_d), .flush_e(flush_e), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count)
  );

  branch_predict_resolver #(.PREDICT_MODE(PRED_STATIC_NT)) u_static (
    .clk(clk), .rst_n(rst_n), .d_pc(d_pc), .d_pred_taken(s_pred_taken),
    .e_valid(e_valid), .e_stall(e_stall), .e_is_branch(e_is_branch),
    .e_is_jump(e_is_jump), .e_pc(e_pc), .e_pred_taken(e_pred_taken),
    .e_actual_taken(e_actual_taken), .e_target(e_target), .flag(s_flag),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .redirect_pc(s_redirect_pc),
    .mispredict_count(s_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  // Expected resolution outcome from the current inputs.
  function automatic logic [32:0] model_resolve();
    if (rst_n !== 1'b1 || !e_valid || e_stall) return 33'd0;
    if (e_is_jump) return {1'b1, e_target};
    if (e_is_branch && e_pred_taken != e_actual_taken)
      return {1'b1, (e_actual_taken ? e_target : e_pc + 32'd4)};
    return 33'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_cnt   = 32'd0;
    m_cnt_s = 32'd0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    logic [32:0] r;
    r = model_resolve();
    if (rst_n === 1'b1) begin
      if (r[32] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (r[32] && m_cnt_s != 32'hFFFF_FFFF) m_cnt_s = m_cnt_s + 32'd1;
      if (e_valid && !e_stall && e_is_branch && !e_is_jump) begin
        if (e_actual_taken) m_bht[idx_of(e_pc)] = (m_bht[idx_of(e_pc)] == 3) ? 3 : m_bht[idx_of(e_pc)] + 1;
        else                m_bht[idx_of(e_pc)] = (m_bht[idx_of(e_pc)] == 0) ? 0 : m_bht[idx_of(e_pc)] - 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] r;
    r = model_resolve();
    check("pred",       {31'd0, d_pred_taken}, {31'd0, m_bht[idx_of(d_pc)] >= 2});
    check("flag",       {31'd0, flag},    {31'd0, r[32]});
    check("flush_d",    {31'd0, flush_d}, {31'd0, r[32]});
    check("flush_e",    {31'd0, flush_e}, {31'd0, r[32]});
    check("redirect",   redirect_pc, r[31:0]);
    check("count",      mispredict_count, m_cnt);
    check("s_pred",     {31'd0, s_pred_taken}, 32'd0);
    check("s_flag",     {31'd0, s_flag},  {31'd0, r[32]});
    check("s_flush",    {30'd0, s_flush_d, s_flush_e}, {30'd0, r[32], r[32]});
    check("s_redirect", s_redirect_pc, r[31:0]);
    check("s_count",    s_count, m_cnt_s);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    e_valid = 0; e_stall = 0; e_is_branch = 0; e_is_jump = 0;
    e_pc = 0; e_target = 0; e_pred_taken = 0; e_actual_taken = 0;
  endtask

  task automatic branch(input logic [31:0] pc, input logic pred, input logic act,
                        input logic [31:0] tgt);
    e_valid = 1; e_stall = 0; e_is_branch = 1; e_is_jump = 0;
    e_pc = pc; e_pred_taken = pred; e_actual_taken = act; e_target = tgt;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    d_pc = 0;
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    for (int i = 0; i < 16; i++) begin
      d_pc = i << 2;
      #0.1;
      check("reset_pred", {31'd0, d_pred_taken}, 32'd0);
    end
    check("reset_count", mispredict_count, 32'd0);
    cyc();

    for (int i = 0; i < 4; i++) begin
      branch(32'h100, 1'b1, 1'b1, 32'h500);
      cyc();
    end
    idle();
    d_pc = 32'h100;
    #1;
    check("train_entry", {30'd0, u_dut.u_bht.entries[0]}, 32'd3);
    check("train_pred", {31'd0, d_pred_taken}, 32'd1);
    check("static_pred", {31'd0, s_pred_taken}, 32'd0);
    branch(32'h100, 1'b1, 1'b1, 32'h500);
    cyc();
    idle();
    check("train_sat", {30'd0, u_dut.u_bht.entries[0]}, 32'd3);
    check("count_before", mispredict_count, 32'd0);

    branch(32'h200, 1'b1, 1'b0, 32'h900);
    #1;
    check("mis_flag", {29'd0, flag, flush_d, flush_e}, 32'd7);
    check("mis_redirect", redirect_pc, 32'h204);
    cyc();
    idle();
    check("mis_count", mispredict_count, 32'd1);

    e_valid = 1; e_is_branch = 1; e_is_jump = 1; e_pc = 32'h100;
    e_target = 32'h80; e_pred_taken = 0; e_actual_taken = 1;
    #1;
    check("jump_flag", {31'd0, flag}, 32'd1);
    check("jump_redirect", redirect_pc, 32'h80);
    cyc();
    idle();
    check("jump_bht", {30'd0, u_dut.u_bht.entries[0]}, 32'd2);

    branch(32'h200, 1'b1, 1'b0, 32'h900);
    e_stall = 1;
    #1;
    check("stall_flag", {31'd0, flag}, 32'd0);
    cyc();
    idle();
    check("stall_bht", {30'd0, u_dut.u_bht.entries[0]}, 32'd2);
    check("stall_count", mispredict_count, 32'd2);

    d_pc = 32'h40;
    branch(32'h40, 1'b1, 1'b0, 32'h900);
    #1;
    check("hazard_old", {31'd0, d_pred_taken}, 32'd1);
    cyc();
    idle();
    check("hazard_new", {31'd0, d_pred_taken}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        branch(32'h44, 1'b0, 1'b1, 32'h10);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_abandon", {30'd0, u_dut.u_bht.entries[1]}, 32'd1);
      end
      d_pc           = {$urandom_range(0, 63), 2'($urandom)};
      e_pc           = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 63), 2'($urandom)};
      e_target       = $urandom;
      e_valid        = ($urandom_range(0, 9) < 8);
      e_stall        = ($urandom_range(0, 9) < 2);
      e_is_branch    = $urandom_range(0, 1);
      e_is_jump      = ($urandom_range(0, 9) < 2);
      e_pred_taken   = $urandom_range(0, 1);
      e_actual_taken = $urandom_range(0, 1);
      cyc();
    end
    idle();
    cyc();

    force u_dut.mispredict_count_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release u_dut.mispredict_count_q;
    #1;
    check("preload", mispredict_count, 32'hFFFF_FFFE);
    branch(32'h300, 1'b0, 1'b1, 32'h700);
    cyc();
    check("sat_reach", mispredict_count, 32'hFFFF_FFFF);
    cyc();
    idle();
    check("sat_hold", mispredict_count, 32'hFFFF_FFFF);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
